// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial signed subtractor, r = a - b, LSB first
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     request, sampled only in IDLE
//   a, b      signed minuend / subtrahend, latched on the accepted start edge
//   busy      high while bits are being processed (SUB)
//   done      one-cycle pulse, r and overflow valid in this cycle
//   r         a - b modulo 2^WIDTH, held until the next completion
//   overflow  signed overflow of the last completed operation
module serial_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_sign;
    logic             b_sign;

    logic             ai;
    logic             bi;
    logic             diff_bit;
    logic             borrow_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign ai          = a_sr[0];
    assign bi          = b_sr[0];
    assign diff_bit    = ai ^ bi ^ borrow;
    assign borrow_next = (~ai & bi) | (~(ai ^ bi) & borrow);
    assign last_bit    = (cnt == CW'(WIDTH - 1));
    // Result fills from the MSB side, so after WIDTH shifts bit 0 is the LSB.
    assign res_next    = {diff_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r        <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        a_sign <= a[WIDTH-1];
                        b_sign <= b[WIDTH-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= res_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // Final borrow is dropped; the MSB just produced is diff_bit.
                        r        <= res_next;
                        overflow <= (a_sign != b_sign) && (diff_bit != a_sign);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 6;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .r        (r),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One operation; returns at the falling edge inside the done cycle.
    // With hold=1, start stays high and a/b are scrambled during SUB.
    task automatic do_op(input int ai, input int bi, input int er, input int eo,
                         input bit hold, input string tag);
        int nbusy;
        int guard;
        @(negedge clk);
        a     = WIDTH'(ai);
        b     = WIDTH'(bi);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        else begin
            a = '0;
            b = '0;
        end
        nbusy = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) nbusy++;
            guard++;
            @(negedge clk);
        end
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_cycles"}, nbusy, WIDTH);
        check({tag, "_r"}, int'(r), er);
        check({tag, "_ovf"}, int'(overflow), eo);
        check({tag, "_busy_in_done"}, int'(busy), 0);
    endtask

    initial begin
        int period;
        int guard;
        int ndone;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_r", int'(r), 0);
        check("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(5, 3, 2, 0, 1'b0, "5m3");
        do_op(-32, 1, 31, 1, 1'b0, "m32m1");
        do_op(31, -1, 32, 1, 1'b0, "31mm1");
        do_op(-5, -5, 0, 0, 1'b0, "m5mm5");
        do_op(-1, 31, 32, 0, 1'b0, "m1m31");

        // Start held through SUB with a/b changing: one operation only.
        do_op(10, 4, 6, 0, 1'b1, "hold");
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) ndone++;
        end
        check("hold_no_relaunch", ndone, 0);
        check("hold_r_kept", int'(r), 6);

        // Back-to-back with start held continuously.
        @(negedge clk);
        a     = WIDTH'(1);
        b     = WIDTH'(2);
        start = 1'b1;
        guard = 0;
        while (!done && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        check("b2b_first_done", int'(done), 1);
        check("b2b_first_r", int'(r), 63);
        for (int k = 0; k < 2; k++) begin
            period = 0;
            do begin
                @(negedge clk);
                period++;
            end while (!done && period < 40);
            check("b2b_period", period, WIDTH + 2);
            check("b2b_r", int'(r), 63);
            check("b2b_ovf", int'(overflow), 0);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset during the third SUB cycle.
        a     = WIDTH'(7);
        b     = WIDTH'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_r", int'(r), 0);
        check("arst_ovf", int'(overflow), 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 0);
        reset_n = 1'b1;
        do_op(7, 2, 5, 0, 1'b0, "after_rst");
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("r_held_idle", int'(r), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
